// File: rtl/program_loader_if.sv
// program_loader_if
// Groups the loader's byte-stream handshake, reload request, ROM write port
// and CPU boot status into one bundle.
//   master : the side feeding bytes (UART receiver / bench); drives in_data,
//            in_valid and reload, observes everything else.
//   slave  : the loader itself.
// Signals:
//   in_data[7:0], in_valid, in_ready  byte handshake (transfer on valid&ready)
//   reload                            one-cycle restart request
//   rom_wren, rom_address, rom_write_data  instruction ROM write port
//   cpu_reset_n, done, error          boot status
//   words_loaded                      words written so far in this load
interface program_loader_if #(
  parameter int ROM_ADDRESS_BITWIDTH = 10
);
  logic [7:0]                      in_data;
  logic                            in_valid;
  logic                            in_ready;
  logic                            reload;
  logic                            rom_wren;
  logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address;
  logic [31:0]                     rom_write_data;
  logic                            cpu_reset_n;
  logic                            done;
  logic                            error;
  logic [ROM_ADDRESS_BITWIDTH:0]   words_loaded;

  modport master (
    output in_data, in_valid, reload,
    input  in_ready, rom_wren, rom_address, rom_write_data,
    input  cpu_reset_n, done, error, words_loaded
  );

  modport slave (
    input  in_data, in_valid, reload,
    output in_ready, rom_wren, rom_address, rom_write_data,
    output cpu_reset_n, done, error, words_loaded
  );
endinterface

// File: rtl/program_loader.sv
// program_loader
// Boot-time loader between the UART receiver and the CPU instruction ROM.
// Stream: 4-byte word count N, N data words, 4-byte additive checksum, all
// little-endian. Each data word is written to ROM address k for word k; once
// the checksum matches, the CPU is released from reset.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    program_loader_if.slave (byte handshake, reload, ROM write port,
//          cpu_reset_n / done / error / words_loaded)
module program_loader #(
  parameter int ROM_ADDRESS_BITWIDTH = 10
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);
  localparam int          AW       = ROM_ADDRESS_BITWIDTH;
  localparam logic [32:0] CAPACITY = 33'd1 << AW;

  typedef enum logic [2:0] {
    RECV_LEN,
    RECV_WORD,
    WRITE,
    RECV_SUM,
    DONE,
    ERROR
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [1:0]    r_byteIdx;
  logic [23:0]   r_assembly;
  logic [AW:0]   r_length;
  logic [AW:0]   r_wordsLoaded;
  logic [31:0]   r_accum;
  logic [31:0]   r_writeData;
  logic [AW-1:0] r_romAddress;
  logic          r_done;
  logic          r_error;
  logic          r_cpuResetN;

  logic          w_recvState;
  logic          w_accept;
  logic          w_lastByte;
  logic [31:0]   w_fullWord;
  logic [AW:0]   w_wordsNext;
  logic          w_lenOverflow;

  // Byte acceptance: only while collecting a field, never during a reload
  // request, and never while reset is held.
  assign w_recvState = (r_state == RECV_LEN) || (r_state == RECV_WORD) ||
                       (r_state == RECV_SUM);
  assign bus.in_ready = w_recvState && !reset && !bus.reload;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_lastByte   = w_accept && (r_byteIdx == 2'd3);

  // The 4th byte is the MSB lane, so the complete field is available
  // combinationally in the cycle it arrives and decisions need no extra cycle.
  assign w_fullWord    = {bus.in_data, r_assembly};
  assign w_wordsNext   = r_wordsLoaded + (AW+1)'(1);
  assign w_lenOverflow = {1'b0, w_fullWord} > CAPACITY;

  assign bus.rom_address    = r_romAddress;
  assign bus.rom_write_data = r_writeData;
  assign bus.words_loaded   = r_wordsLoaded;
  assign bus.done           = r_done;
  assign bus.error          = r_error;
  assign bus.cpu_reset_n    = r_cpuResetN;

  // Next-state logic and the ROM write strobe. reload overrides every state.
  always_comb begin
    w_nextState  = r_state;
    bus.rom_wren = 1'b0;
    unique case (r_state)
      RECV_LEN: begin
        if (w_lastByte) begin
          if (w_lenOverflow) begin
            w_nextState = ERROR;
          end else if (w_fullWord == 32'd0) begin
            w_nextState = RECV_SUM;
          end else begin
            w_nextState = RECV_WORD;
          end
        end
      end
      RECV_WORD: begin
        if (w_lastByte) begin
          w_nextState = WRITE;
        end
      end
      WRITE: begin
        bus.rom_wren = 1'b1;
        w_nextState  = (w_wordsNext == r_length) ? RECV_SUM : RECV_WORD;
      end
      RECV_SUM: begin
        if (w_lastByte) begin
          w_nextState = (w_fullWord == r_accum) ? DONE : ERROR;
        end
      end
      DONE:    w_nextState = DONE;
      ERROR:   w_nextState = ERROR;
      default: w_nextState = RECV_LEN;
    endcase
    if (bus.reload) begin
      w_nextState = RECV_LEN;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RECV_LEN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath: byte assembly, latched word count, write-port registers,
  // checksum accumulator and the boot status flags. The status flags follow
  // the next state, so done/cpu_reset_n rise at the same edge that accepts
  // the final checksum byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byteIdx     <= 2'd0;
      r_assembly    <= 24'd0;
      r_length      <= '0;
      r_wordsLoaded <= '0;
      r_accum       <= 32'd0;
      r_writeData   <= 32'd0;
      r_romAddress  <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cpuResetN   <= 1'b0;
    end else begin
      r_done      <= (w_nextState == DONE);
      r_error     <= (w_nextState == ERROR);
      r_cpuResetN <= (w_nextState == DONE);
      if (bus.reload) begin
        r_byteIdx     <= 2'd0;
        r_length      <= '0;
        r_wordsLoaded <= '0;
        r_accum       <= 32'd0;
      end else begin
        if (w_accept) begin
          // The index wraps to 0 after the 4th byte, which starts the next field.
          r_byteIdx <= r_byteIdx + 2'd1;
          case (r_byteIdx)
            2'd0:    r_assembly[7:0]   <= bus.in_data;
            2'd1:    r_assembly[15:8]  <= bus.in_data;
            2'd2:    r_assembly[23:16] <= bus.in_data;
            default: ;
          endcase
        end
        if (w_lastByte && (r_state == RECV_LEN)) begin
          r_length <= w_fullWord[AW:0];
        end
        if (w_lastByte && (r_state == RECV_WORD)) begin
          r_writeData  <= w_fullWord;
          r_romAddress <= r_wordsLoaded[AW-1:0];
        end
        if (r_state == WRITE) begin
          r_accum       <= r_accum + r_writeData;
          r_wordsLoaded <= w_wordsNext;
        end
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
// Self-checking bench for program_loader with a 16-word ROM. A cycle-accurate
// vector table covers the basic and mismatching streams; hand-written
// sequences cover empty/overflow lengths, gapped input, reload, asynchronous
// reset mid-word and a full-capacity load.
module tb_program_loader;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if #(.ROM_ADDRESS_BITWIDTH(AW)) bus();

  program_loader #(.ROM_ADDRESS_BITWIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checksRun    = 0;
  int checksPassed = 0;

  // Every ROM write seen on the port, recorded at the falling edge.
  logic [AW-1:0] wAddr[$];
  logic [31:0]   wData[$];
  logic          prevWren   = 1'b0;
  logic          doubleWren = 1'b0;

  always @(negedge clk) begin
    if (!reset && bus.rom_wren) begin
      wAddr.push_back(bus.rom_address);
      wData.push_back(bus.rom_write_data);
      if (prevWren) doubleWren <= 1'b1;
    end
    prevWren <= bus.rom_wren;
  end

  localparam logic [7:0] BASIC [0:15] = '{
    8'h02, 8'h00, 8'h00, 8'h00,
    8'h13, 8'h05, 8'h10, 8'h00,
    8'h93, 8'h05, 8'h20, 8'h00,
    8'hA6, 8'h0A, 8'h30, 8'h00
  };

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        reload;
    logic        expReady;
    logic        expWren;
    logic [3:0]  expAddr;
    logic [31:0] expData;
    logic [4:0]  expWords;
    logic        expDone;
    logic        expError;
    logic        expCpuRstN;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic v, input logic [7:0] d,
                                 input logic rdy, input logic wr,
                                 input logic [3:0] a, input logic [31:0] wd,
                                 input logic [4:0] w, input logic dn,
                                 input logic er, input logic cr);
    vec_t x;
    x.valid = v; x.data = d; x.reload = 1'b0;
    x.expReady = rdy; x.expWren = wr; x.expAddr = a; x.expData = wd;
    x.expWords = w; x.expDone = dn; x.expError = er; x.expCpuRstN = cr;
    vecs.push_back(x);
  endfunction

  // Cycle-by-cycle table of the basic stream with in_valid held high; a byte
  // offered during a WRITE cycle stays on the bus until the next cycle.
  function automatic void buildStreamTable(input logic [7:0] sum0, input logic good);
    vecs.delete();
    for (int i = 0; i < 4; i++) addVec(1'b1, BASIC[i], 1, 0, 4'd0, 32'd0, 5'd0, 0, 0, 0);
    for (int i = 4; i < 8; i++) addVec(1'b1, BASIC[i], 1, 0, 4'd0, 32'd0, 5'd0, 0, 0, 0);
    addVec(1'b1, BASIC[8], 0, 1, 4'd0, 32'h00100513, 5'd0, 0, 0, 0);
    for (int i = 8; i < 12; i++) addVec(1'b1, BASIC[i], 1, 0, 4'd0, 32'd0, 5'd1, 0, 0, 0);
    addVec(1'b1, sum0, 0, 1, 4'd1, 32'h00200593, 5'd1, 0, 0, 0);
    addVec(1'b1, sum0, 1, 0, 4'd0, 32'd0, 5'd2, 0, 0, 0);
    for (int i = 13; i < 16; i++) addVec(1'b1, BASIC[i], 1, 0, 4'd0, 32'd0, 5'd2, 0, 0, 0);
    addVec(1'b0, 8'h00, 0, 0, 4'd0, 32'd0, 5'd2, good, !good, good);
    addVec(1'b0, 8'h00, 0, 0, 4'd0, 32'd0, 5'd2, good, !good, good);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checksRun++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      checksPassed++;
    end
  endtask

  function automatic logic [45:0] snapAll();
    return {bus.in_ready, bus.rom_wren, bus.rom_address, bus.rom_write_data,
            bus.cpu_reset_n, bus.done, bus.error, bus.words_loaded};
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.in_valid = v.valid;
    bus.in_data  = v.data;
    bus.reload   = v.reload;
  endtask

  task automatic checkOutput(input vec_t v, input string name);
    check({name, " status"},
          {59'd0, bus.in_ready, bus.rom_wren, bus.done, bus.error, bus.cpu_reset_n},
          {59'd0, v.expReady, v.expWren, v.expDone, v.expError, v.expCpuRstN});
    check({name, " words_loaded"}, 64'(bus.words_loaded), 64'(v.expWords));
    if (v.expWren) begin
      check({name, " rom addr/data"}, 64'({bus.rom_address, bus.rom_write_data}),
            64'({v.expAddr, v.expData}));
    end
  endtask

  task automatic runTable(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], $sformatf("%s cycle %0d", tag, i));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Leaves time at 1 unit after a rising edge with reset just released.
  task automatic doReset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.reload = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    wAddr.delete();
    wData.delete();
  endtask

  // Offers one byte after `gap` idle cycles and holds it until accepted.
  // Returns 1 unit after the accepting edge with in_valid low.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    waited = 0;
    #1;
    while (!bus.in_ready && waited < 30) begin
      @(posedge clk); #2;
      waited++;
    end
    if (!bus.in_ready) begin
      checksRun++;
      $display("[TB] FAIL handshake timeout: in_ready=%b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    for (int i = 0; i < 4; i++) begin
      sendByte(w[8*i +: 8], (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap)));
    end
  endtask

  task automatic sendBasic(input int maxGap);
    for (int i = 0; i < 16; i++) begin
      sendByte(BASIC[i], (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap)));
    end
  endtask

  task automatic checkBasicWrites(input string tag);
    check({tag, " write count"}, 64'(wAddr.size()), 64'd2);
    if (wAddr.size() >= 2) begin
      check({tag, " write 0"}, 64'({wAddr[0], wData[0]}), 64'({4'd0, 32'h00100513}));
      check({tag, " write 1"}, 64'({wAddr[1], wData[1]}), 64'({4'd1, 32'h00200593}));
    end
  endtask

  task automatic checkBoot(input string tag, input logic dn, input logic er);
    check({tag, " done/error/cpu_reset_n"},
          {61'd0, bus.done, bus.error, bus.cpu_reset_n}, {61'd0, dn, er, dn});
  endtask

  initial begin
    // Reset values while reset is held, then in_ready right after release.
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.reload = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset values", 64'(snapAll()), 64'd0);
    reset = 1'b0;
    #1;
    check("in_ready after reset release", 64'(bus.in_ready), 64'd1);
    #1;
    @(posedge clk); #1;
    check("idle stays in RECV_LEN", 64'({bus.in_ready, bus.words_loaded}), 64'({1'b1, 5'd0}));

    // Basic load, cycle-accurate.
    doReset();
    buildStreamTable(8'hA6, 1'b1);
    runTable("basic");
    checkBasicWrites("basic");

    // Checksum mismatch.
    doReset();
    buildStreamTable(8'hA7, 1'b0);
    runTable("mismatch");
    checkBasicWrites("mismatch");

    // Empty program.
    doReset();
    for (int i = 0; i < 8; i++) sendByte(8'h00, 0);
    checkBoot("empty", 1'b1, 1'b0);
    check("empty no writes", 64'(wAddr.size()), 64'd0);

    // Length one past capacity.
    doReset();
    sendWord(32'd17, 0);
    check("overflow 17 error/ready", 64'({bus.error, bus.in_ready, bus.done}), 64'({3'b100}));
    repeat (3) begin @(posedge clk); #1; end
    check("overflow 17 no writes", 64'(wAddr.size()), 64'd0);

    // Length with only high-order bits set.
    doReset();
    sendWord(32'h01000000, 0);
    checkBoot("overflow 2^24", 1'b0, 1'b1);

    // Gapped input.
    doReset();
    sendBasic(7);
    checkBoot("gapped", 1'b1, 1'b0);
    checkBasicWrites("gapped");
    check("gapped words_loaded", 64'(bus.words_loaded), 64'd2);

    // Reload during the 2nd data word; the byte offered with reload is dropped.
    doReset();
    for (int i = 0; i < 10; i++) sendByte(BASIC[i], 0);
    check("pre-reload words_loaded", 64'(bus.words_loaded), 64'd1);
    bus.reload = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h55;
    #1;
    check("in_ready during reload", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.reload = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("after reload status",
          64'({bus.cpu_reset_n, bus.done, bus.error, bus.in_ready, bus.words_loaded}),
          64'({4'b0001, 5'd0}));
    wAddr.delete(); wData.delete();
    @(posedge clk); #1;
    sendBasic(0);
    checkBoot("reload reload-then-load", 1'b1, 1'b0);
    checkBasicWrites("after reload");

    // Reload out of DONE.
    bus.reload = 1'b1;
    @(posedge clk); #1;
    bus.reload = 1'b0;
    #1;
    check("reload from DONE", 64'({bus.done, bus.cpu_reset_n, bus.in_ready}), 64'({3'b001}));
    @(posedge clk); #1;

    // Asynchronous reset in the middle of the 2nd word.
    doReset();
    for (int i = 0; i < 10; i++) sendByte(BASIC[i], 0);
    check("pre-reset write data", 64'(bus.rom_write_data), 64'h00100513);
    reset = 1'b1;
    #1;
    check("reset mid-word all outputs", 64'(snapAll()), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wAddr.delete(); wData.delete();
    sendBasic(0);
    checkBoot("load after mid-word reset", 1'b1, 1'b0);
    checkBasicWrites("after reset");

    // Full capacity: 16 words of k*0x01010101, checksum 0x78787878.
    doReset();
    sendWord(32'd16, 0);
    for (int k = 0; k < 16; k++) sendWord(32'(k) * 32'h01010101, 0);
    sendWord(32'h78787878, 0);
    checkBoot("full capacity", 1'b1, 1'b0);
    check("full words_loaded", 64'(bus.words_loaded), 64'd16);
    check("full write count", 64'(wAddr.size()), 64'd16);
    if (wAddr.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        check($sformatf("full write %0d", k), 64'({wAddr[k], wData[k]}),
              64'({4'(k), 32'(k) * 32'h01010101}));
      end
    end

    repeat (2) @(posedge clk);
    #1;
    check("no back-to-back rom_wren", 64'(doubleWren), 64'd0);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction loader sitting directly upstream of the CPU's instruction ROM and its fetch stage. It consumes a byte stream from the UART receiver and assembles little-endian 32-bit words. It writes those words sequentially into the instruction ROM's write port and verifies a trailing additive checksum. On success it releases the CPU's reset so fetch starts at PC 0 with the freshly loaded program.

## Interface
Parameters:
- ROM_ADDRESS_BITWIDTH, default 10: width of the ROM word address; capacity is 2^ROM_ADDRESS_BITWIDTH words.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  received byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle. A byte transfers when in_valid & in_ready.
- reload  input  1  synchronous one-cycle request to restart loading.
- rom_wren  output  1  one-cycle write strobe to the instruction ROM.
- rom_address  output  ROM_ADDRESS_BITWIDTH  word address for the write.
- rom_write_data  output  32  word to write.
- cpu_reset_n  output  1  active-low reset to the CPU core; high only in DONE.
- done  output  1  program loaded and checksum matched.
- error  output  1  length overflow or checksum mismatch.
- words_loaded  output  ROM_ADDRESS_BITWIDTH+1  count of words written so far.

## Operation
- Stream format: 4-byte word count N, then N data words, then a 4-byte checksum. All fields are little-endian, LSB byte first.
- Checksum = sum of all N data words mod 2^32; N = 0 requires a checksum of 0.
- States:
  - RECV_LEN: collect 4 bytes. After the 4th byte:
    - N > 2^ROM_ADDRESS_BITWIDTH -> ERROR.
    - N = 0 -> RECV_SUM.
    - Otherwise -> RECV_WORD.
  - RECV_WORD: collect 4 bytes, then -> WRITE.
  - WRITE: one cycle; rom_wren = 1; accumulate the checksum and increment words_loaded. Then:
    - words_loaded (after increment) == N -> RECV_SUM.
    - Otherwise -> RECV_WORD.
  - RECV_SUM: collect 4 bytes. After the 4th byte: assembled value == accumulator -> DONE, else -> ERROR.
  - DONE, ERROR: sticky; in_ready = 0. Leave only on reload or reset.
- in_ready = 1 in RECV_LEN, RECV_WORD, RECV_SUM, and only when reload = 0 (combinational).
- A 2-bit byte index selects the target byte lane and resets to 0 at each field start.
- rom_address = words_loaded[ROM_ADDRESS_BITWIDTH-1:0] at the WRITE cycle. Word k goes to address k.
- reload in any state, next edge:
  - state -> RECV_LEN.
  - Byte index, accumulator, N and words_loaded are cleared.
  - done = error = 0, cpu_reset_n = 0.
  - A byte offered in the reload cycle is not accepted, because in_ready is 0.
- Bytes with in_valid = 0 are ignored. Any number of idle cycles between bytes is allowed.

## Timing
- Reset values:
  - State RECV_LEN.
  - rom_wren 0, rom_address 0, rom_write_data 0.
  - cpu_reset_n 0, done 0, error 0, words_loaded 0.
  - in_ready 0 while reset is asserted, 1 in the first cycle after release.
- Word write: the 4th byte of a data word is accepted at edge t. rom_wren = 1 and rom_address/rom_write_data are valid in cycle t+1 (WRITE). in_ready = 0 in cycle t+1 and is 1 again in cycle t+2.
- Minimum throughput: 5 cycles per data word.
- Checksum decision: the 4th checksum byte is accepted at edge t. done/error and cpu_reset_n are registered at the same edge, so cpu_reset_n = 1 from cycle t+1.
- Length overflow: error = 1 in the cycle after the 4th length byte; no ROM write occurs.
- N = 2^ROM_ADDRESS_BITWIDTH: the last write goes to the all-ones address; rom_address never wraps to 0 within one load.
- Reset asserted mid-load: all outputs return to reset values immediately (asynchronous), and any partial word is discarded.
- rom_wren is never asserted outside WRITE.

## Test plan
- Basic load:
  - Stimulus: 02 00 00 00, 13 05 10 00, 93 05 20 00, then checksum A6 0A 30 00, with in_valid held high.
  - Required: ROM writes 0x00100513 @0 and 0x00200593 @1, each one-cycle rom_wren. done = 1, cpu_reset_n = 1 one cycle after the last byte; error = 0; words_loaded = 2.
- Checksum mismatch:
  - Stimulus: same stream with checksum A7 0A 30 00.
  - Required: both words written, error = 1, done = 0, cpu_reset_n stays 0, in_ready = 0 afterwards.
- Empty and overflow:
  - N = 0 with checksum 0 -> done = 1 with no rom_wren.
  - With ROM_ADDRESS_BITWIDTH = 4, N = 17 -> error = 1 after the 4th length byte and no writes.
- Gapped input: the basic stream with random 0-7 idle cycles (in_valid = 0) between bytes -> identical writes and done.
- Reload and reset:
  - reload pulsed during the 2nd data word -> cpu_reset_n = 0, words_loaded = 0. A subsequent full basic stream loads correctly from address 0.
  - reset asserted mid-word -> all outputs at reset values the same cycle.
- Full capacity: ROM_ADDRESS_BITWIDTH = 4, N = 16 words of value k*0x01010101 -> addresses 0..15 written in order, checksum 0x78787878 accepted, done = 1.
